// File: rtl/display_digit_scanner.sv
// display_digit_scanner
//   Converts an 8-bit binary reading to three BCD digits, using a sequential
//   double-dabble that takes 8 cycles. It also multiplexes those digits onto
//   a 7-segment display.
//   Optional macro LEADING_ZERO_BLANK_EN turns off the hundreds and tens
//   selects when those digits are leading zeros.
module display_digit_scanner #(
  parameter int SCAN_DIVIDER = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  value,
  input  logic        load,
  output logic        busy,
  output logic [11:0] bcd,
  output logic [3:0]  digit_value,
  output logic [2:0]  digit_select
);

  // Prescaler width: at least 1 bit, so that SCAN_DIVIDER=1 still works.
  localparam int PW = (SCAN_DIVIDER > 1) ? $clog2(SCAN_DIVIDER) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIVIDER - 1);

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t      state_q, state_d;
  logic [2:0]  iter_q, iter_d;
  logic [7:0]  bin_q, bin_d;
  logic [11:0] work_q, work_d;
  logic [11:0] bcd_q, bcd_d;
  logic [11:0] adj;

  logic [PW-1:0] presc_q;
  logic [1:0]    idx_q;

  // Add 3 to every BCD nibble that is 5 or more, so the nibble carries
  // correctly on the next shift.
  function automatic logic [11:0] dabble_adjust(input logic [11:0] w);
    logic [11:0] r;
    for (int n = 0; n < 3; n++) begin
      r[n*4 +: 4] = (w[n*4 +: 4] >= 4'd5) ? w[n*4 +: 4] + 4'd3 : w[n*4 +: 4];
    end
    return r;
  endfunction

  // Converter next state: accept a load in IDLE, then run one iteration per cycle.
  always_comb begin
    // NOTE: every signal this block drives gets a default first. A path
    // that leaves one unassigned would infer a latch.
    state_d = state_q;
    iter_d  = iter_q;
    bin_d   = bin_q;
    work_d  = work_q;
    bcd_d   = bcd_q;
    adj     = dabble_adjust(work_q);
    case (state_q)
      IDLE: begin
        if (load) begin
          bin_d   = value;
          work_d  = '0;
          iter_d  = '0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        {work_d, bin_d} = {adj, bin_q} << 1;
        iter_d = iter_q + 3'd1;
        // Publish only the finished result, so bcd never shows a partial value.
        if (iter_q == 3'd7) begin
          bcd_d   = work_d;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Converter registers, with synchronous reset that aborts any conversion.
  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments. Every flop then
    // samples its pre-edge value, and the result does not depend on
    // simulation order.
    if (reset) begin
      state_q <= IDLE;
      iter_q  <= '0;
      bin_q   <= '0;
      work_q  <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      bin_q   <= bin_d;
      work_q  <= work_d;
      bcd_q   <= bcd_d;
    end
  end

  // Free-running scan prescaler. The digit index advances 0->1->2->0 on
  // each terminal count.
  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (presc_q == PRESC_LAST) begin
      presc_q <= '0;
      idx_q   <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // Digit mux and one-hot select. These depend only on registers.
  always_comb begin
    digit_value  = bcd_q[3:0];
    digit_select = 3'b001;
    case (idx_q)
      2'd1: begin
        digit_value  = bcd_q[7:4];
        digit_select = 3'b010;
`ifdef LEADING_ZERO_BLANK_EN
        if (bcd_q[11:4] == 8'h00) digit_select = 3'b000;
`endif
      end
      2'd2: begin
        digit_value  = bcd_q[11:8];
        digit_select = 3'b100;
`ifdef LEADING_ZERO_BLANK_EN
        if (bcd_q[11:8] == 4'h0) digit_select = 3'b000;
`endif
      end
      default: begin
        digit_value  = bcd_q[3:0];
        digit_select = 3'b001;
      end
    endcase
  end

  assign busy = (state_q == CONVERT);
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_display_digit_scanner.sv
// Bench for display_digit_scanner. It drives directed vectors and checks
// every cycle against a decimal-arithmetic model. Two instances are used:
// SCAN_DIVIDER=4 and SCAN_DIVIDER=1.
module tb_display_digit_scanner;

  localparam int DIV_A = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  value;
  logic        load;
  logic        busy, busy_b;
  logic [11:0] bcd, bcd_b;
  logic [3:0]  digit_value, digit_value_b;
  logic [2:0]  digit_select, digit_select_b;

  int n_cmp = 0;
  int n_bad = 0;

  display_digit_scanner #(.SCAN_DIVIDER(DIV_A)) dut (
    .clock(clock), .reset(reset), .value(value), .load(load),
    .busy(busy), .bcd(bcd), .digit_value(digit_value), .digit_select(digit_select)
  );

  display_digit_scanner #(.SCAN_DIVIDER(1)) dut_b (
    .clock(clock), .reset(reset), .value(value), .load(load),
    .busy(busy_b), .bcd(bcd_b), .digit_value(digit_value_b), .digit_select(digit_select_b)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [11:0] to_bcd(input int v);
    return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  function automatic logic [2:0] exp_sel(input int slot, input logic [11:0] b);
    logic [2:0] s;
    s = 3'(1 << slot);
`ifdef LEADING_ZERO_BLANK_EN
    if (slot == 2 && b[11:8] == 4'h0) s = 3'b000;
    if (slot == 1 && b[11:4] == 8'h00) s = 3'b000;
`endif
    return s;
  endfunction

  function automatic logic [3:0] exp_dv(input int slot, input logic [11:0] b);
    return 4'((b >> (4 * slot)) & 12'hF);
  endfunction

  bit          m_valid = 1'b0;
  bit          m_busy  = 1'b0;
  int          m_remain = 0;
  int          m_val = 0;
  int          m_c = 0;       // cycles since reset released
  logic [11:0] m_bcd = '0;

  // Model: a conversion finishes 8 edges after acceptance. The scan slot is
  // (elapsed cycles / divider) mod 3.
  always @(posedge clock) begin
    if (reset) begin
      m_valid  <= 1'b1;
      m_busy   <= 1'b0;
      m_remain <= 0;
      m_bcd    <= '0;
      m_c      <= 0;
    end else begin
      m_c <= m_c + 1;
      if (m_busy) begin
        m_remain <= m_remain - 1;
        if (m_remain == 1) begin
          m_busy <= 1'b0;
          m_bcd  <= to_bcd(m_val);
        end
      end else if (load) begin
        m_val    <= int'(value);
        m_busy   <= 1'b1;
        m_remain <= 8;
      end
    end
  end

  // Per-cycle compare, sampled 1 time unit after the active edge.
  always @(posedge clock) begin
    #1;
    if (m_valid) begin
      check("busy",      busy,           m_busy);
      check("bcd",       bcd,            m_bcd);
      check("dv",        digit_value,    exp_dv((m_c / DIV_A) % 3, m_bcd));
      check("sel",       digit_select,   exp_sel((m_c / DIV_A) % 3, m_bcd));
      check("bcd_b",     bcd_b,          m_bcd);
      check("dv_b",      digit_value_b,  exp_dv(m_c % 3, m_bcd));
      check("sel_b",     digit_select_b, exp_sel(m_c % 3, m_bcd));
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_load(input logic [7:0] v);
    @(negedge clock);
    value = v;
    load  = 1'b1;
    @(negedge clock);
    load  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20) check("wait_idle_timeout", 1, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int len;
    logic [2:0] cur;
    logic [2:0] prev;
    logic [3:0] want;

    reset = 1'b1;
    load  = 1'b0;
    value = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_bcd",  bcd, 12'h000);
    check("rst_dv",   digit_value, 4'h0);
    check("rst_sel",  digit_select, 3'b001);
    reset = 1'b0;

    // 255: busy for exactly 8 cycles, then 12'h255
    do_load(8'd255);
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      @(negedge clock);
    end
    check("busy_len_255", n, 8);
    check("bcd_255", bcd, 12'h255);

    // 0 then 9
    do_load(8'd0);
    wait_idle();
    check("bcd_0", bcd, 12'h000);
    do_load(8'd9);
    wait_idle();
    check("bcd_9", bcd, 12'h009);
    // 12 cycles is 3 whole slots, so the units slot takes 4 of them
    // wherever the window starts.
    n = 0;
    len = 0;
    repeat (12) begin
      if (digit_select == 3'b001) n++;
      if (digit_select == 3'b000) len++;
      @(negedge clock);
    end
    check("units_cycles_9", n, 4);
`ifdef LEADING_ZERO_BLANK_EN
    check("blank_cycles_9", len, 8);
`else
    check("blank_cycles_9", len, 0);
`endif

    // 137: select 001/010/100 for 4 cycles each, with digits 7/3/1
    do_load(8'd137);
    wait_idle();
    check("bcd_137", bcd, 12'h137);
    prev = digit_select;
    n = 0;
    while (digit_select == prev && n < 10) begin
      @(negedge clock);
      n++;
    end
    for (int r = 0; r < 6; r++) begin
      cur = digit_select;
      want = (cur == 3'b001) ? 4'd7 : (cur == 3'b010) ? 4'd3 : 4'd1;
      len = 0;
      while (digit_select == cur && len < 10) begin
        check("scan_dv_137", digit_value, want);
        len++;
        @(negedge clock);
      end
      check("scan_run_len", len, 4);
      check("scan_order", digit_select,
            (cur == 3'b001) ? 3'b010 : (cur == 3'b010) ? 3'b100 : 3'b001);
    end

    // A load of 42 three cycles into the conversion of 100 is ignored.
    do_load(8'd100);
    @(negedge clock);
    do_load(8'd42);
    wait_idle();
    check("bcd_100", bcd, 12'h100);
    repeat (3) begin
      @(negedge clock);
      check("no_queue_busy", busy, 0);
    end

    // A load on the edge where busy falls is not accepted.
    do_load(8'd50);
    repeat (6) @(negedge clock);
    do_load(8'd77);
    check("edge_load_busy", busy, 0);
    check("edge_load_bcd", bcd, 12'h050);
    repeat (3) @(negedge clock);
    check("edge_load_busy_later", busy, 0);

    // Reset on the 5th conversion cycle of 200 aborts the conversion.
    do_load(8'd200);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort_busy", busy, 0);
    check("abort_bcd", bcd, 12'h000);
    reset = 1'b0;
    do_load(8'd200);
    wait_idle();
    check("bcd_200", bcd, 12'h200);

    // Back-to-back sweep over 1..255
    for (int v = 1; v < 256; v++) begin
      do_load(8'(v));
      wait_idle();
      check("sweep_bcd", bcd, to_bcd(v));
    end

    repeat (4) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
